ram_stream_reader: RTL and testbench
====================================

// Module: ram_stream_reader
// PURPOSE
//   Read DMA stage sitting directly on the port of a single-port RAM (1RW, 1-cycle read latency, data_out held when en=0).
//   Accepts a (base, length) command, issues sequential reads, and streams the words out on a valid/ready interface.
//   Absorbs the RAM's fixed read latency with a small credit-controlled FIFO so downstream backpressure never drops data.
//   Sustains 1 word/cycle when out_ready is held high.
// PARAMETERS
//   ADDR_BITS   14  RAM address width; addresses wrap modulo 2**ADDR_BITS.
//   DATA_BITS   64  RAM/stream word width.
//   FIFO_DEPTH  2   output buffer entries; legal >= 2.
// PORTS
//   clock        in   1             single clock, all state on posedge.
//   reset_n      in   1             asynchronous, active-low reset.
//   cmd_valid    in   1             command offered.
//   cmd_ready    out  1             high only in IDLE.
//   cmd_base     in   ADDR_BITS     first word address.
//   cmd_len      in   ADDR_BITS+1   word count; 0 = no-op.
//   ram_en       out  1             RAM enable; one read per high cycle.
//   ram_wr_en    out  1             constant 0.
//   ram_addr     out  ADDR_BITS     RAM address.
//   ram_data_in  out  DATA_BITS     constant 0.
//   ram_data_out in   DATA_BITS     RAM read data, valid the cycle after ram_en.
//   out_valid    out  1             stream word available (FIFO not empty).
//   out_ready    in   1             stream sink accepts.
//   out_data     out  DATA_BITS     FIFO head.
//   out_last     out  1             head is final word of the command.
//   done         out  1             one-cycle pulse at command completion.
// BEHAVIOUR
//   Reset: state IDLE, FIFO empty, inflight=0, counters 0; ram_en=0, ram_addr=0, out_valid=0, out_last=0,
//     out_data=0, done=0, cmd_ready=1. Reset mid-command discards all issued and buffered words.
//   States: IDLE -> RUN on cmd accept (cmd_valid&cmd_ready) with cmd_len!=0; RUN -> DRAIN when last read issued;
//     DRAIN -> IDLE on pop of word with out_last. Zero-length accept stays IDLE, pulses done next cycle, no ram_en.
//   Issue rule (RUN only): ram_en=1 iff count + inflight - pop < FIFO_DEPTH, pop = out_valid&out_ready.
//     inflight = ram_en registered (read issued previous cycle). Never more than FIFO_DEPTH words owned.
//   ram_addr: base on first issue, then +1 (or +stride) after each issue; wraps at 2**ADDR_BITS. ram_addr is
//     registered; ram_en combinational from registered count/inflight and out_ready.
//   Capture: when inflight=1, ram_data_out pushed into FIFO at that clock edge, tagged last if it is word cmd_len-1.
//   Latency: accept at edge 0 -> first ram_en in cycle 1 -> push at end of cycle 2 -> out_valid in cycle 3.
//   Push and pop in the same cycle: both occur, count unchanged. FIFO full cannot be pushed (guaranteed by credit).
//   done pulses the cycle after the last-word pop; cmd_ready rises in that same cycle.
//   out_data/out_last stable while out_valid&!out_ready; order always matches address order.
//   cmd_valid ignored outside IDLE; cmd_base/cmd_len sampled only on accept.
// CONFIGURATION
//   RAM_STREAM_STRIDE_EN defined: extra port cmd_stride in ADDR_BITS, sampled on accept; address advances by
//     stride modulo 2**ADDR_BITS; stride 0 rereads the same word cmd_len times.
//   Undefined: no cmd_stride port; address advances by 1.
// TESTING
//   1. mem[0x10..0x13]=A0..A3, cmd base=0x10 len=4, out_ready=1 -> A0..A3 on 4 consecutive cycles starting
//      3 cycles after accept, out_last only on A3, done pulse next cycle, ram_en high exactly 4 cycles.
//   2. Same cmd, out_ready low 6 cycles after first valid, then random -> outstanding (FIFO+inflight) never
//      > FIFO_DEPTH, words A0..A3 exactly once in order, out_data stable while stalled.
//   3. ADDR_BITS=4, base=0xE len=4 -> ram_addr sequence 0xE,0xF,0x0,0x1.
//   4. cmd len=0 -> no ram_en, no out_valid, done pulse 1 cycle after accept, cmd_ready stays 1.
//   5. reset_n low after 2 of 8 words delivered -> all outputs at reset values immediately; after release
//      new cmd base=0 len=2 delivers mem[0],mem[1] with out_last on second.
//   6. RAM_STREAM_STRIDE_EN defined, base=0 stride=3 len=3 -> addresses 0,3,6; stride=0 len=2 -> 0,0.

Source files
------------

// File: rtl/ram_stream_reader.sv
// Streaming read DMA on a 1RW RAM port: turns a (base, len) command into sequential reads and a valid/ready word stream.
// Optional macro RAM_STREAM_STRIDE_EN adds a cmd_stride port (address step sampled on accept); otherwise the step is 1.
module ram_stream_reader #(
    parameter int ADDR_BITS  = 14,
    parameter int DATA_BITS  = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_BITS-1:0] cmd_base,
    input  logic [ADDR_BITS:0]   cmd_len,
`ifdef RAM_STREAM_STRIDE_EN
    input  logic [ADDR_BITS-1:0] cmd_stride,
`endif
    output logic                 ram_en,
    output logic                 ram_wr_en,
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [DATA_BITS-1:0] ram_data_in,
    input  logic [DATA_BITS-1:0] ram_data_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_last,
    output logic                 done
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_BITS:0] LEN_ONE = 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                 state_reg, state_next;
    logic [ADDR_BITS-1:0]   addr_reg;
    logic [ADDR_BITS-1:0]   step;
    logic [ADDR_BITS:0]     len_reg;
    logic [ADDR_BITS:0]     issue_cnt_reg;
    logic [ADDR_BITS:0]     cap_cnt_reg;
    logic                   inflight_reg;
    logic                   done_reg;
    logic [CW-1:0]          count_reg;
    logic [PW-1:0]          rd_ptr_reg, wr_ptr_reg;
    logic [DATA_BITS:0]     fifo_mem [FIFO_DEPTH];
    logic [DATA_BITS:0]     head;
    logic                   accept, pop, push, issue, last_issue, cap_last;

`ifdef RAM_STREAM_STRIDE_EN
    logic [ADDR_BITS-1:0]   stride_reg;
    assign step = stride_reg;
`else
    assign step = ADDR_BITS'(1);
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign cmd_ready   = (state_reg == S_IDLE);
    assign accept      = cmd_valid & cmd_ready;
    assign out_valid   = (count_reg != '0);
    assign pop         = out_valid & out_ready;
    assign push        = inflight_reg;
    assign head        = fifo_mem[rd_ptr_reg];
    assign out_data    = head[DATA_BITS-1:0];
    assign out_last    = out_valid & head[DATA_BITS];
    assign done        = done_reg;
    assign ram_wr_en   = 1'b0;
    assign ram_data_in = '0;
    assign ram_addr    = addr_reg;

    // Credit check: words buffered plus the read in flight, minus the one leaving this cycle, must leave room.
    assign issue      = (state_reg == S_RUN) &&
                        ((32'(count_reg) + 32'(inflight_reg)) < (FIFO_DEPTH + 32'(pop)));
    assign ram_en     = issue;
    assign last_issue = issue && (issue_cnt_reg == len_reg - LEN_ONE);
    assign cap_last   = (cap_cnt_reg == len_reg - LEN_ONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept && (cmd_len != '0)) state_next = S_RUN;
            S_RUN:   if (last_issue)                state_next = S_DRAIN;
            S_DRAIN: if (pop && out_last)           state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            addr_reg      <= '0;
            len_reg       <= '0;
            issue_cnt_reg <= '0;
            cap_cnt_reg   <= '0;
            inflight_reg  <= 1'b0;
            done_reg      <= 1'b0;
            count_reg     <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
`ifdef RAM_STREAM_STRIDE_EN
            stride_reg    <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            inflight_reg <= issue;
            done_reg     <= (accept && (cmd_len == '0)) || (pop && out_last);
            if (accept) begin
                addr_reg      <= cmd_base;
                len_reg       <= cmd_len;
                issue_cnt_reg <= '0;
                cap_cnt_reg   <= '0;
`ifdef RAM_STREAM_STRIDE_EN
                stride_reg    <= cmd_stride;
`endif
            end else if (issue) begin
                addr_reg      <= addr_reg + step;
                issue_cnt_reg <= issue_cnt_reg + LEN_ONE;
            end
            if (push) begin
                cap_cnt_reg <= cap_cnt_reg + LEN_ONE;
                wr_ptr_reg  <= ptr_inc(wr_ptr_reg);
            end
            if (pop) rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            if (push && !pop)      count_reg <= count_reg + CW'(1);
            else if (!push && pop) count_reg <= count_reg - CW'(1);
        end
    end

    // Each entry holds {last, data}; the read word is captured the cycle after its ram_en.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else if (push) begin
            fifo_mem[wr_ptr_reg] <= {cap_last, ram_data_out};
        end
    end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: RAM model, queue-based reference of expected addresses and words.
module tb_ram_stream_reader;
    localparam int AB = 14;
    localparam int DB = 64;
    localparam int FD = 2;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AB-1:0] cmd_base;
    logic [AB:0]   cmd_len;
    logic [AB-1:0] cmd_stride;
    logic          ram_en, ram_wr_en;
    logic [AB-1:0] ram_addr;
    logic [DB-1:0] ram_data_in, ram_data_out, ram_q;
    logic          out_valid, out_ready, out_last, done;
    logic [DB-1:0] out_data;

    logic [DB-1:0] mem [2**AB];
    logic [DB-1:0] exp_data_q [$];
    logic [AB-1:0] exp_addr_q [$];
    int            total = 0;
    int            bad = 0;
    int            issued = 0;
    int            popped = 0;
    logic          prev_stall = 1'b0;
    logic          prev_last;
    logic [DB-1:0] prev_data;

    ram_stream_reader #(.ADDR_BITS(AB), .DATA_BITS(DB), .FIFO_DEPTH(FD)) dut (
        .clock(clock), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
`ifdef RAM_STREAM_STRIDE_EN
        .cmd_stride(cmd_stride),
`endif
        .ram_en(ram_en), .ram_wr_en(ram_wr_en), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (ram_en) ram_q <= mem[ram_addr];
    assign ram_data_out = ram_q;

    task automatic check(input string tag, input logic [DB-1:0] obs, input logic [DB-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: word i of a command lives at (base + i*stride) mod 2**AB.
    task automatic enqueue(input logic [AB-1:0] base, input int len, input logic [AB-1:0] stride);
        logic [AB-1:0] step;
        logic [AB-1:0] a;
`ifdef RAM_STREAM_STRIDE_EN
        step = stride;
`else
        step = AB'(1);
`endif
        for (int i = 0; i < len; i++) begin
            a = AB'((int'(base) + i * int'(step)) % (2**AB));
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem[a]);
        end
    endtask

    always @(posedge clock) begin
        if (reset_n) begin
            if (ram_en) issued++;
            if (out_valid && out_ready) popped++;
        end
    end

    always @(negedge clock) begin
        if (reset_n) begin
            check("wr_en_zero", {63'd0, ram_wr_en}, 64'd0);
            check("outstanding_le_depth", {63'd0, (issued - popped) <= FD}, 64'd1);
            if (ram_en) begin
                check("addr_expected", {63'd0, exp_addr_q.size() > 0}, 64'd1);
                if (exp_addr_q.size() > 0) check("ram_addr", {50'd0, ram_addr}, {50'd0, exp_addr_q.pop_front()});
            end
            if (prev_stall) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_data", out_data, prev_data);
                check("stall_last", {63'd0, out_last}, {63'd0, prev_last});
            end
            if (out_valid && out_ready) begin
                check("word_expected", {63'd0, exp_data_q.size() > 0}, 64'd1);
                if (exp_data_q.size() > 0) begin
                    check("out_last", {63'd0, out_last}, {63'd0, exp_data_q.size() == 1});
                    check("out_data", out_data, exp_data_q.pop_front());
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            $display("cyc t=%0t en=%0b addr=%0h valid=%0b ready=%0b data=%0h last=%0b done=%0b",
                     $time, ram_en, ram_addr, out_valid, out_ready, out_data, out_last, done);
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Presents one command for a single edge (DUT must be idle); leaves the bench 1 ns after the accept edge.
    task automatic issue_cmd(input logic [AB-1:0] base, input int len, input logic [AB-1:0] stride);
        cmd_valid  = 1'b1;
        cmd_base   = base;
        cmd_len    = (AB+1)'(len);
        cmd_stride = stride;
        enqueue(base, len, stride);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_done(input bit rand_ready);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock);
            #1;
            if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        check("cmd_ready_at_done", {63'd0, cmd_ready}, 64'd1);
        check("words_left", 64'(exp_data_q.size()), 64'd0);
        check("addrs_left", 64'(exp_addr_q.size()), 64'd0);
        @(posedge clock);
        #1;
        out_ready = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ram_en"},    {63'd0, ram_en}, 64'd0);
        check({tag, "_ram_addr"},  {50'd0, ram_addr}, 64'd0);
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd0);
        check({tag, "_out_last"},  {63'd0, out_last}, 64'd0);
        check({tag, "_out_data"},  out_data, 64'd0);
        check({tag, "_done"},      {63'd0, done}, 64'd0);
        check({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        bit hit;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_base = '0; cmd_len = '0; cmd_stride = '0; out_ready = 1'b0;
        for (int i = 0; i < 2**AB; i++) mem[i] = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) mem[16 + i] = 64'hA0A0_0000_0000_0000 + 64'(i);
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // 1: unstalled stream, exact cycle timing relative to the accept edge
        out_ready = 1'b1;
        issue_cmd(14'h10, 4, 14'd1);
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            check($sformatf("t1_ram_en_c%0d", k),    {63'd0, ram_en},    {63'd0, k <= 4});
            check($sformatf("t1_valid_c%0d", k),     {63'd0, out_valid}, {63'd0, k >= 3 && k <= 6});
            check($sformatf("t1_last_c%0d", k),      {63'd0, out_last},  {63'd0, k == 6});
            check($sformatf("t1_done_c%0d", k),      {63'd0, done},      {63'd0, k == 7});
            check($sformatf("t1_cmd_ready_c%0d", k), {63'd0, cmd_ready}, {63'd0, k == 7});
        end
        check("t1_words_left", 64'(exp_data_q.size()), 64'd0);
        @(posedge clock);
        #1;

        // 2: stalled start, then random backpressure
        out_ready = 1'b0;
        issue_cmd(14'h10, 4, 14'd1);
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (out_valid) begin
                hit = 1'b1;
                break;
            end
        end
        check("t2_first_valid", {63'd0, hit}, 64'd1);
        repeat (6) @(posedge clock);
        #1;
        out_ready = 1'($urandom_range(0, 1));
        run_until_done(1'b1);

        // 3: address wrap at the top of the space
        issue_cmd(14'h3FFE, 4, 14'd1);
        run_until_done(1'b0);

        // 4: zero-length command
        issue_cmd(14'h5, 0, 14'd1);
        for (int k = 1; k <= 2; k++) begin
            @(negedge clock);
            check($sformatf("t4_done_c%0d", k),      {63'd0, done},      {63'd0, k == 1});
            check($sformatf("t4_ram_en_c%0d", k),    {63'd0, ram_en},    64'd0);
            check($sformatf("t4_valid_c%0d", k),     {63'd0, out_valid}, 64'd0);
            check($sformatf("t4_cmd_ready_c%0d", k), {63'd0, cmd_ready}, 64'd1);
        end
        @(posedge clock);
        #1;

        // 5: reset in the middle of an 8-word command
        p0 = popped;
        issue_cmd(14'h100, 8, 14'd1);
        hit = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (popped - p0 >= 2) begin
                hit = 1'b1;
                break;
            end
        end
        check("t5_two_delivered", {63'd0, hit}, 64'd1);
        reset_n = 1'b0;
        exp_data_q.delete();
        exp_addr_q.delete();
        #1;
        check_reset_outputs("t5_midreset");
        @(posedge clock);
        #1;
        issued = 0;
        popped = 0;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        issue_cmd(14'h0, 2, 14'd1);
        run_until_done(1'b0);

        // random commands with random backpressure
        for (int n = 0; n < 6; n++) begin
            out_ready = 1'($urandom_range(0, 1));
            issue_cmd(AB'($urandom), int'($urandom_range(1, 12)), 14'd1);
            run_until_done(1'b1);
        end

`ifdef RAM_STREAM_STRIDE_EN
        // 6: strided and zero-stride reads
        issue_cmd(14'h0, 3, 14'd3);
        run_until_done(1'b0);
        issue_cmd(14'h0, 2, 14'd0);
        run_until_done(1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
